// File: rtl/csa_pkg.sv
// Shared helpers for the carry-save multi-operand adder: output width and
// reduction-tree shape.
package csa_pkg;

  // Output width that holds the exact sum of num_ops operands of width bits.
  function automatic int unsigned csa_out_w(input int unsigned width,
                                            input int unsigned num_ops);
    return width + $clog2(num_ops);
  endfunction

  // One 3:2 level: each full group of three becomes two; leftovers pass through.
  function automatic int unsigned csa_step(input int unsigned n);
    return (n > 2) ? (2 * (n / 3) + (n % 3)) : n;
  endfunction

  // Number of vectors present after i reduction levels.
  function automatic int unsigned csa_count(input int unsigned n, input int unsigned i);
    int unsigned c;
    c = n;
    for (int unsigned j = 0; j < i; j++) begin
      c = csa_step(c);
    end
    return c;
  endfunction

  // Number of 3:2 levels needed to reach two vectors.
  function automatic int unsigned csa_levels(input int unsigned n);
    int unsigned c;
    int unsigned lv;
    c  = n;
    lv = 0;
    while (c > 2) begin
      c  = csa_step(c);
      lv = lv + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational W-bit 3:2 compressor: one full-adder cell per bit. The carry
// vector comes out already weighted (shifted left by one, top carry dropped).
module csa_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy_shifted
);

  assign cy_shifted[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i > 0) begin : g_cy
      assign cy_shifted[i] = (a[i-1] & b[i-1]) | (a[i-1] & c[i-1]) | (b[i-1] & c[i-1]);
    end
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined multi-operand adder: registered 3:2 carry-save levels followed by a
// registered carry-propagate adder, with valid/ready flow control per stage.
// Build option: define CSA_SIGNED_OPS_EN for two's-complement operands
// (sign extension); otherwise operands are unsigned (zero extension).
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NUM_OPS    = 4,
  parameter int unsigned OUT_W      = csa_out_w(WIDTH, NUM_OPS),
  parameter int unsigned NUM_LEVELS = csa_levels(NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sum
);

  // Stages 0..NUM_LEVELS-1 hold reduction levels; stage NUM_LEVELS holds the sum.
  logic [NUM_LEVELS:0] valid_q, valid_d;
  logic [NUM_LEVELS:0] load, adv;
  logic [OUT_W-1:0]    ext_ops [NUM_OPS];
  logic [OUT_W-1:0]    sum_q;

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
`ifdef CSA_SIGNED_OPS_EN
    assign ext_ops[k] = {{(OUT_W-WIDTH){in_ops[k*WIDTH+WIDTH-1]}}, in_ops[k*WIDTH +: WIDTH]};
`else
    assign ext_ops[k] = {{(OUT_W-WIDTH){1'b0}}, in_ops[k*WIDTH +: WIDTH]};
`endif
  end

  // Backward stall chain: a stage can take data if empty or if it is moving on.
  always_comb begin
    logic rdy;
    rdy      = out_ready;
    adv      = '0;
    load     = '0;
    in_ready = 1'b0;
    for (int s = int'(NUM_LEVELS); s >= 0; s--) begin
      adv[s] = valid_q[s] & rdy;
      rdy    = ~valid_q[s] | rdy;
    end
    in_ready = rdy;
    load[0]  = in_valid & rdy;
    for (int unsigned s = 1; s <= NUM_LEVELS; s++) begin
      load[s] = adv[s-1];
    end
    valid_d = load | (valid_q & ~adv);
  end

  // Stage valid bits; cleared asynchronously so in-flight beats are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lvl
    localparam int unsigned NIn  = csa_count(NUM_OPS, l);
    localparam int unsigned NOut = csa_count(NUM_OPS, l + 1);
    localparam int unsigned NGrp = NIn / 3;

    logic [OUT_W-1:0] src   [NIn];
    logic [OUT_W-1:0] red   [NOut];
    logic [OUT_W-1:0] vec_q [NOut];

    if (l == 0) begin : g_src_in
      for (genvar k = 0; k < NIn; k++) begin : g_k
        assign src[k] = ext_ops[k];
      end
    end else begin : g_src_lvl
      for (genvar k = 0; k < NIn; k++) begin : g_k
        assign src[k] = g_lvl[l-1].vec_q[k];
      end
    end

    for (genvar g = 0; g < NGrp; g++) begin : g_grp
      csa_row #(
        .W(OUT_W)
      ) u_row (
        .a         (src[3*g]),
        .b         (src[3*g+1]),
        .c         (src[3*g+2]),
        .s         (red[2*g]),
        .cy_shifted(red[2*g+1])
      );
    end

    for (genvar j = 0; j < NIn - 3 * NGrp; j++) begin : g_pass
      assign red[2*NGrp+j] = src[3*NGrp+j];
    end

    // Level register; loads only when a beat moves in.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < NOut; k++) begin
          vec_q[k] <= '0;
        end
      end else if (load[l]) begin
        for (int unsigned k = 0; k < NOut; k++) begin
          vec_q[k] <= red[k];
        end
      end
    end
  end

  // Final carry-propagate add of the two remaining vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (load[NUM_LEVELS]) begin
      sum_q <= g_lvl[NUM_LEVELS-1].vec_q[0] + g_lvl[NUM_LEVELS-1].vec_q[1];
    end
  end

  assign out_valid = valid_q[NUM_LEVELS];
  assign out_sum   = sum_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder (WIDTH=8, NUM_OPS=4): directed beats,
// backpressure, mid-stream reset and full-rate streaming against a sum model.
module tb_csa_pipe_adder;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned OW = 10;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [N*W-1:0] in_ops   = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_sum;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [OW-1:0] exp_q [$];
  logic          in_fire    = 1'b0;
  logic          saw_block  = 1'b0;
  logic          stall_prev = 1'b0;
  logic [OW-1:0] sum_prev   = '0;

  always #5 clk = ~clk;

  csa_pipe_adder #(
    .WIDTH  (W),
    .NUM_OPS(N)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ops   (in_ops),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Exact arithmetic sum of the operands, reduced modulo 2^OW.
  function automatic logic [OW-1:0] model_sum(input logic [N*W-1:0] ops);
    int acc;
    logic [W-1:0] op;
    acc = 0;
    for (int k = 0; k < int'(N); k++) begin
      op = ops[k*W +: W];
`ifdef CSA_SIGNED_OPS_EN
      acc = acc + int'($signed(op));
`else
      acc = acc + int'(op);
`endif
    end
    return acc[OW-1:0];
  endfunction

  // Scoreboard: transfers are decided by values stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_fire    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
        check_eq("hold_sum", {22'd0, out_sum}, {22'd0, sum_prev});
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check_eq("out_without_in", {31'd0, out_valid}, 32'd0);
        else check_eq("sum", {22'd0, out_sum}, {22'd0, exp_q.pop_front()});
      end
      stall_prev = out_valid && !out_ready;
      sum_prev   = out_sum;
      in_fire    = in_valid && in_ready;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_fire) exp_q.push_back(model_sum(in_ops));
    end
  end

  // One beat into an empty pipe; result must appear exactly 3 cycles later.
  task automatic single(input logic [N*W-1:0] ops, input logic [OW-1:0] exp, input string tag);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_ops    = ops;
    out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_valid = 1'b0;
      if (c < 3) check_eq({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    end
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_sum"}, {22'd0, out_sum}, {22'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [OW-1:0] exp3;
    logic [N*W-1:0] ops;
    int sent;
    int stall_cnt;
    logic got_first;
    int gaps;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_sum", {22'd0, out_sum}, 32'd0);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed beats
    single(32'h04030201, 10'h00A, "t1");
    single(32'hFFFFFFFF, 10'h3FC, "t2");
`ifdef CSA_SIGNED_OPS_EN
    exp3 = 10'h000;
`else
    exp3 = 10'h100;
`endif
    single({8'h00, 8'h01, 8'h80, 8'h7F}, exp3, "t3");

    // Backpressure: 10 beats, 5-cycle stall after first result
    n_out     = 0;
    saw_block = 1'b0;
    sent      = 0;
    stall_cnt = 0;
    got_first = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && n_out < 10; cyc++) begin
      @(posedge clk); #1;
      if (in_valid && in_fire) begin
        sent++;
        in_valid = 1'b0;
      end
      if (sent < 10 && !in_valid) begin
        in_valid = 1'b1;
        in_ops   = $urandom;
      end
      if (out_valid) got_first = 1'b1;
      if (got_first && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    check_eq("t4_count", n_out, 32'd10);
    check_eq("t4_blocked", {31'd0, saw_block}, 32'd1);
    check_eq("t4_leftover", exp_q.size(), 32'd0);

    // Reset with three beats in flight
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_ops   = $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("t5_full", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t5_rst_sum", {22'd0, out_sum}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ops = $urandom;
    single(ops, model_sum(ops), "t5");

    // Full throughput for 100 cycles
    n_out = 0;
    gaps  = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (c >= 3 && !out_valid) gaps++;
      if (c >= 1 && !in_ready) gaps++;
      in_valid = 1'b1;
      in_ops   = $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check_eq("t6_gaps", gaps, 32'd0);
    check_eq("t6_count", n_out, 32'd100);
    check_eq("t6_leftover", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
